// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: eight-LED pattern sequencer with four modes (FILL, CHASE,
// BLINK, OFF). A DIV_W-bit prescaler, shortened by the 2-bit rate select,
// produces step strobes; each strobe advances the pattern step. LED outputs
// are active-low. mode_next cycles the mode at any time and restarts the
// pattern at step 0.
// Optional build macro: LED_SEQ_BOUNCE_EN turns CHASE into a 14-step ping-pong.
module led_seq_ctrl #(
  parameter int unsigned DIV_W = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_next,
  input  logic [1:0] rate,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_CHASE = 2'd1,
    S_BLINK = 2'd2,
    S_OFF   = 2'd3
  } mode_t;

  mode_t            r_mode;
  mode_t            w_mode_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_mask;
  logic [3:0]       r_step;
  logic [3:0]       w_step_nxt;
  logic [3:0]       w_step_adv;
  logic [7:0]       r_led;
  logic [7:0]       w_led_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_strobe;
`ifdef LED_SEQ_BOUNCE_EN
  // 0 = counting up, 1 = counting down
  logic             r_dir;
  logic             w_dir_nxt;
  logic             w_dir_adv;
`endif

  // Active-low LED pattern for a given mode and step.
  function automatic logic [7:0] f_led(input mode_t m, input logic [3:0] s);
    logic [7:0] lit;
    lit = '0;
    case (m)
      S_FILL: begin
        if (!s[3]) lit = 8'hFF >> (3'd7 - s[2:0]);  // bits 0..k
        else       lit = 8'hFF << s[2:0];           // bits (k-8)..7
      end
      S_CHASE: lit = 8'h01 << s[2:0];
      S_BLINK: lit = s[0] ? 8'h00 : 8'hFF;
      default: lit = '0;
    endcase
    return ~lit;
  endfunction

  // Strobe when the low DIV_W-rate prescaler bits are all ones; OFF never steps.
  always_comb begin
    w_mask   = {DIV_W{1'b1}} >> rate;
    w_strobe = en && (r_mode != S_OFF) && ((r_cnt & w_mask) == w_mask);
  end

  // Mode FSM next state: mode_next steps through the four modes, ignoring en.
  always_comb begin
    w_mode_nxt = r_mode;
    if (mode_next) begin
      case (r_mode)
        S_FILL:  w_mode_nxt = S_CHASE;
        S_CHASE: w_mode_nxt = S_BLINK;
        S_BLINK: w_mode_nxt = S_OFF;
        default: w_mode_nxt = S_FILL;
      endcase
    end
  end

  // Step value after a strobe, wrapping at the current mode's cycle length.
  always_comb begin
    w_step_adv = r_step;
`ifdef LED_SEQ_BOUNCE_EN
    w_dir_adv  = r_dir;
`endif
    case (r_mode)
      S_FILL:  w_step_adv = r_step + 4'd1;
      S_CHASE: begin
`ifdef LED_SEQ_BOUNCE_EN
        // Turn around at each end so the ends are shown once per pass.
        if (!r_dir) begin
          if (r_step[2:0] == 3'd7) begin
            w_step_adv = 4'd6;
            w_dir_adv  = 1'b1;
          end else begin
            w_step_adv = {1'b0, r_step[2:0] + 3'd1};
          end
        end else begin
          if (r_step[2:0] == 3'd1) begin
            w_step_adv = 4'd0;
            w_dir_adv  = 1'b0;
          end else begin
            w_step_adv = {1'b0, r_step[2:0] - 3'd1};
          end
        end
`else
        w_step_adv = {1'b0, r_step[2:0] + 3'd1};
`endif
      end
      S_BLINK: w_step_adv = {3'b000, ~r_step[0]};
      default: w_step_adv = '0;
    endcase
  end

  // Datapath next state: mode_next beats a coincident strobe; en=0 freezes.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_step_nxt = r_step;
    w_led_nxt  = r_led;
    w_tick_nxt = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    w_dir_nxt  = r_dir;
`endif
    if (mode_next) begin
      w_cnt_nxt  = '0;
      w_step_nxt = '0;
      w_led_nxt  = f_led(w_mode_nxt, 4'd0);
`ifdef LED_SEQ_BOUNCE_EN
      w_dir_nxt  = 1'b0;
`endif
    end else if (w_strobe) begin
      w_cnt_nxt  = '0;
      w_step_nxt = w_step_adv;
      w_led_nxt  = f_led(r_mode, w_step_adv);
      w_tick_nxt = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
      w_dir_nxt  = w_dir_adv;
`endif
    end else if (en && (r_mode != S_OFF)) begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) r_mode <= S_FILL;
    else     r_mode <= w_mode_nxt;
  end

  // Prescaler, step, LED and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_step <= '0;
      r_led  <= 8'hFE;
      r_tick <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir  <= 1'b0;
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_step <= w_step_nxt;
      r_led  <= w_led_nxt;
      r_tick <= w_tick_nxt;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir  <= w_dir_nxt;
`endif
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench for led_seq_ctrl at DIV_W=4. A behavioural
// model predicts each cycle's outputs into a queue; the entry is popped and
// compared after the clock edge. Honours LED_SEQ_BOUNCE_EN like the design.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, mode_next;
  logic [1:0] rate;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  led_seq_ctrl #(.DIV_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_next(mode_next), .rate(rate),
    .led(led), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic       tick;
    logic [1:0] mode;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int   m_cnt, m_step, m_mode;
  logic m_tick;
  logic [7:0] fill_tbl [16];
  int   chase_pos [14];

  function automatic int chase_len();
`ifdef LED_SEQ_BOUNCE_EN
    return 14;
`else
    return 8;
`endif
  endfunction

  function automatic logic [7:0] m_led(input int md, input int st);
    logic [7:0] one;
    one = 8'h01;
    case (md)
      0: return fill_tbl[st];
      1: begin
`ifdef LED_SEQ_BOUNCE_EN
        return ~(one << chase_pos[st]);
`else
        return ~(one << st);
`endif
      end
      2: return (st % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, predict, then compare after the edge.
  task automatic cyc(input logic r, input logic e, input logic mn, input logic [1:0] rt);
    exp_t x;
    int   per;
    rst = r; en = e; mode_next = mn; rate = rt;
    per = 1 << (4 - int'(rt));
    if (r) begin
      m_cnt = 0; m_step = 0; m_mode = 0; m_tick = 1'b0;
    end else if (mn) begin
      m_mode = (m_mode + 1) % 4; m_cnt = 0; m_step = 0; m_tick = 1'b0;
    end else if (e && m_mode != 3) begin
      if (m_cnt == per - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        case (m_mode)
          0: m_step = (m_step + 1) % 16;
          1: m_step = (m_step + 1) % chase_len();
          default: m_step = (m_step + 1) % 2;
        endcase
      end else begin
        m_cnt  = m_cnt + 1;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    x.led = m_led(m_mode, m_step); x.tick = m_tick; x.mode = 2'(m_mode);
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("led", led, x.led);
    chk("tick", {7'd0, tick}, {7'd0, x.tick});
    chk("mode", {6'd0, mode}, {6'd0, x.mode});
  endtask

  initial begin
    int ticks;
    int guard;
    fill_tbl = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    chase_pos = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
    m_cnt = 0; m_step = 0; m_mode = 0; m_tick = 1'b0;
    rst = 1'b1; en = 1'b0; mode_next = 1'b0; rate = 2'd0;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 3);
    chk("rst_led", led, 8'hFE);
    chk("rst_mode", {6'd0, mode}, 8'd0);

    // First tick 16 cycles after release at rate 0
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
    chk("no_early_tick", {7'd0, tick}, 8'd0);
    cyc(0, 1, 0, 0);
    chk("first_tick", {7'd0, tick}, 8'd1);
    chk("first_led", led, 8'hFC);

    // Full FILL cycle at rate 3
    for (int i = 0; i < 36; i++) cyc(0, 1, 0, 3);

    // mode_next coinciding with a strobe at FILL step 5
    guard = 0;
    while (!(m_mode == 0 && m_step == 5 && m_cnt == 1) && guard < 200) begin
      cyc(0, 1, 0, 3); guard++;
    end
    chk("reach_fill5", 8'(guard < 200), 8'd1);
    cyc(0, 1, 1, 3);
    chk("mn_mode", {6'd0, mode}, 8'd1);
    chk("mn_tick", {7'd0, tick}, 8'd0);
    chk("mn_led", led, 8'hFE);

    // CHASE turnaround / wrap from step 7
    guard = 0;
    while (!(m_step == 7 && m_cnt == 1) && guard < 200) begin
      cyc(0, 1, 0, 3); guard++;
    end
    chk("reach_chase7", 8'(guard < 200), 8'd1);
    chk("chase7_led", led, 8'h7F);
    cyc(0, 1, 0, 3);
`ifdef LED_SEQ_BOUNCE_EN
    chk("chase_after7", led, 8'hBF);
`else
    chk("chase_after7", led, 8'hFE);
`endif
    for (int i = 0; i < 34; i++) cyc(0, 1, 0, 3);

    // BLINK freeze with en=0, then resume with the remaining period
    cyc(0, 1, 1, 1);
    chk("blink_led0", led, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1);
    chk("frozen_led", led, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1);
    chk("resume_no_tick", {7'd0, tick}, 8'd0);
    cyc(0, 1, 0, 1);
    chk("resume_tick", {7'd0, tick}, 8'd1);
    chk("resume_led", led, 8'hFF);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1);

    // OFF: dark and silent
    cyc(0, 1, 1, 3);
    chk("off_mode", {6'd0, mode}, 8'd3);
    ticks = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(0, 1, 0, 3);
      if (tick) ticks++;
    end
    chk("off_ticks", 8'(ticks), 8'd0);
    chk("off_led", led, 8'hFF);
    cyc(0, 1, 1, 3);
    chk("wrap_mode", {6'd0, mode}, 8'd0);
    chk("wrap_led", led, 8'hFE);

    // Reset in mid-sequence beats en and mode_next, then resume
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 3);
    cyc(1, 1, 1, 3);
    chk("midrst_led", led, 8'hFE);
    chk("midrst_mode", {6'd0, mode}, 8'd0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 22, prescaler width; legal range 4..30.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  run enable; 0 freezes the sequence.
REQ-005 SHALL have port mode_next  input  1  single-cycle pulse that advances the mode.
REQ-006 SHALL have port rate  input  2  step-rate select.
REQ-007 SHALL have port led  output  8  LED drive, active-low (0 = lit), registered.
REQ-008 SHALL have port mode  output  2  current mode, registered.
REQ-009 SHALL have port tick  output  1  single-cycle pulse on every step advance, registered.

Function
REQ-010 SHALL hold a DIV_W-bit prescaler cnt that increments by 1 each cycle while en=1 and holds while en=0.
REQ-011 SHALL raise an internal step strobe when en=1 and cnt[DIV_W-1-rate:0] are all ones, then clear cnt to 0 on the next edge; step period is 2^(DIV_W-rate) cycles.
REQ-012 SHALL hold a 4-bit step counter that advances once per step strobe and wraps at the mode's cycle length.
REQ-013 SHALL implement a mode FSM FILL(0) -> CHASE(1) -> BLINK(2) -> OFF(3) -> FILL, advancing on mode_next=1 regardless of en.
REQ-014 SHALL, on a mode change, clear step, cnt and direction on the same edge; led shows step 0 of the new mode from the next cycle.
REQ-015 SHALL let mode_next win when it coincides with a step strobe: no step advance, tick=0.
REQ-016 FILL: 16-step cycle; step k=0..7 lights bits 0..k; step k=8..15 lights bits (k-8)..7; step 0 led=8'hFE, step 7 8'h00, step 8 8'h00, step 15 8'h7F.
REQ-017 CHASE: exactly one lit LED at bit step[2:0]; 8-step cycle 0..7, wraps 7->0.
REQ-018 BLINK: 2-step cycle; even step led=8'h00, odd step led=8'hFF.
REQ-019 OFF: led=8'hFF; step and cnt held at 0; no tick.
REQ-020 SHALL update led, step and tick on the same edge; a strobe in cycle N gives the new led and tick=1 in cycle N+1; tick lasts exactly one cycle.
REQ-021 SHALL keep led, step, mode and cnt unchanged while en=0, except for mode_next handling.
REQ-022 SHALL never produce an led value outside the tables above for the current mode.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, set mode=0, step=0, cnt=0, direction=up, tick=0, led=8'hFE.
REQ-024 SHALL give rst priority over en, mode_next and the step strobe, including a reset in the middle of a sequence.
REQ-025 SHALL resume counting from cnt=0 on the first edge with rst=0 and en=1.

Configuration
REQ-026 SHALL honour macro LED_SEQ_BOUNCE_EN.
- Defined: CHASE runs a 14-step ping-pong 0,1..7,6..1,0; direction flips at bit 7 and at bit 0.
- Undefined: CHASE wraps 7->0 per REQ-017 and the direction register is absent.
REQ-027 SHALL leave FILL, BLINK and OFF identical with or without the macro.

Verification (DIV_W=4)
REQ-028 rst=1 then en=1, rate=0 -> led=8'hFE; first tick 16 cycles after reset release; led=8'hFC after it.
REQ-029 FILL, rate=3 -> tick every 2 cycles; led sequence FE,FC,F8,F0,E0,C0,80,00,00,01,03,07,0F,1F,3F,7F, then FE.
REQ-030 mode_next pulse in the same cycle as a strobe in FILL step 5 -> mode=1, tick=0, led=8'hFE next cycle.
REQ-031 CHASE, rate=3, at step 7 -> with LED_SEQ_BOUNCE_EN next led=8'hBF; without it next led=8'hFE.
REQ-032 en=0 for 40 cycles in BLINK with led=8'h00 -> led, cnt and tick frozen; en=1 resumes with the same remaining period.
REQ-033 four mode_next pulses from FILL -> mode 1,2,3,0; in OFF led=8'hFF and no tick over 64 cycles.
